// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rstseq.sv
// Reset sequencer for a bank of async set/reset flops: synchronized, staggered RN release
// followed by a handshaked SETN preset pulse. Every output is a flop.
module gf180mcu_fd_sc_mcu9t5v0__rstseq #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned HOLD_CYCLES = 8,
   parameter int unsigned NOUT        = 4,
   parameter int unsigned SET_CYCLES  = 2
) (
   input  logic            CLK,
   input  logic            RN,
   input  logic            PRE_REQ,
   output logic [NOUT-1:0] RN_OUT,
   output logic            SETN_OUT,
   output logic            PRE_ACK,
   output logic            READY
);

   typedef enum logic [2:0] {StRst, StSync, StHold, StRel, StRun, StPset, StPack} state_e;

   state_e                 r_state, w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_req;
   logic [7:0]             r_cnt, w_cnt_nxt;
   logic [NOUT-1:0]        r_rn_out, w_rn_out_nxt, w_rn_shift;
   logic                   r_setn, w_setn_nxt;
   logic                   r_ack, w_ack_nxt;
   logic                   r_ready, w_ready_nxt;
   logic                   w_sync_done, w_hold_done, w_pset_done;

   assign w_rn_shift  = (r_rn_out << 1) | NOUT'(1'b1);
   assign w_sync_done = r_sync[SYNC_STAGES-1];
   assign w_hold_done = (r_cnt <= 8'd1);
   assign w_pset_done = (r_cnt == 8'd0);

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         r_state <= StRst;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // PRE_REQ is registered before the FSM acts on it, so a request held through
   // the release sequence is serviced on the first edge after RUN is entered.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         r_sync   <= '0;
         r_req    <= 1'b0;
         r_cnt    <= 8'd0;
         r_rn_out <= '0;
         r_setn   <= 1'b1;
         r_ack    <= 1'b0;
         r_ready  <= 1'b0;
      end else begin
         r_sync   <= {r_sync[SYNC_STAGES-2:0], 1'b1};
         r_req    <= PRE_REQ;
         r_cnt    <= w_cnt_nxt;
         r_rn_out <= w_rn_out_nxt;
         r_setn   <= w_setn_nxt;
         r_ack    <= w_ack_nxt;
         r_ready  <= w_ready_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StRst:  w_state_nxt = StSync;
         StSync: if (w_sync_done) w_state_nxt = StHold;
         StHold: begin
            if (w_hold_done) begin
               if (NOUT == 1) w_state_nxt = StRun;
               else           w_state_nxt = StRel;
            end
         end
         StRel:  if (w_rn_shift[NOUT-1]) w_state_nxt = StRun;
         StRun:  if (r_req) w_state_nxt = StPset;
         StPset: if (w_pset_done) w_state_nxt = StPack;
         StPack: if (!PRE_REQ) w_state_nxt = StRun;
         default: w_state_nxt = StRst;
      endcase
   end

   always_comb begin
      w_cnt_nxt    = r_cnt;
      w_rn_out_nxt = r_rn_out;
      w_setn_nxt   = r_setn;
      w_ack_nxt    = r_ack;
      w_ready_nxt  = r_ready;
      case (r_state)
         StSync: if (w_sync_done) w_cnt_nxt = 8'(HOLD_CYCLES);
         StHold: begin
            if (w_hold_done) begin
               w_rn_out_nxt = NOUT'(1'b1);
               if (NOUT == 1) w_ready_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         StRel: begin
            w_rn_out_nxt = w_rn_shift;
            if (w_rn_shift[NOUT-1]) w_ready_nxt = 1'b1;
         end
         StRun: begin
            if (r_req) begin
               w_setn_nxt  = 1'b0;
               w_ready_nxt = 1'b0;
               w_cnt_nxt   = 8'(SET_CYCLES - 1);
            end
         end
         StPset: begin
            if (w_pset_done) begin
               w_setn_nxt = 1'b1;
               w_ack_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         StPack: begin
            if (!PRE_REQ) begin
               w_ack_nxt   = 1'b0;
               w_ready_nxt = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign RN_OUT   = r_rn_out;
   assign SETN_OUT = r_setn;
   assign PRE_ACK  = r_ack;
   assign READY    = r_ready;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__rstseq.sv
// Directed bench for the reset sequencer: default instance plus a SYNC=4/HOLD=1/NOUT=1 instance.
module tb_gf180mcu_fd_sc_mcu9t5v0__rstseq;

   logic       CLK = 1'b0;
   logic       RN, PRE_REQ;
   logic [3:0] RN_OUT;
   logic       SETN_OUT, PRE_ACK, READY;
   logic       RN2, PRE_REQ2;
   logic [0:0] RN_OUT2;
   logic       SETN_OUT2, PRE_ACK2, READY2;
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 CLK = ~CLK;

   gf180mcu_fd_sc_mcu9t5v0__rstseq u_dut (
      .CLK      (CLK),
      .RN       (RN),
      .PRE_REQ  (PRE_REQ),
      .RN_OUT   (RN_OUT),
      .SETN_OUT (SETN_OUT),
      .PRE_ACK  (PRE_ACK),
      .READY    (READY)
   );

   gf180mcu_fd_sc_mcu9t5v0__rstseq #(
      .SYNC_STAGES (4),
      .HOLD_CYCLES (1),
      .NOUT        (1),
      .SET_CYCLES  (2)
   ) u_dut2 (
      .CLK      (CLK),
      .RN       (RN2),
      .PRE_REQ  (PRE_REQ2),
      .RN_OUT   (RN_OUT2),
      .SETN_OUT (SETN_OUT2),
      .PRE_ACK  (PRE_ACK2),
      .READY    (READY2)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_rn"},    16'(RN_OUT), 16'h0);
      chk({tag, "_setn"},  16'(SETN_OUT), 16'h1);
      chk({tag, "_ack"},   16'(PRE_ACK), 16'h0);
      chk({tag, "_ready"}, 16'(READY), 16'h0);
   endtask

   // SETN low is only legal while every RN_OUT bit is released.
   always @(negedge CLK) begin
      if (RN === 1'b1 && SETN_OUT === 1'b0) chk("inv_setn_rn", 16'(RN_OUT), 16'hF);
   end

   initial begin
      RN = 1'b1; RN2 = 1'b1; PRE_REQ = 1'b0; PRE_REQ2 = 1'b0;
      #2 RN = 1'b0; RN2 = 1'b0;
      #1 chk_rst("por");
      step();
      step();
      chk_rst("por_hold");
      @(negedge CLK);
      RN = 1'b1; RN2 = 1'b1;

      // Release sequence: RN_OUT[0] at edge 11, full release and READY at edge 14.
      for (int e = 1; e <= 14; e++) begin
         step();
         chk("rel_setn", 16'(SETN_OUT), 16'h1);
         if (e == 5) chk("d2_e5_ready", 16'(READY2), 16'h0);
         if (e == 5) chk("d2_e5_rn", 16'(RN_OUT2), 16'h0);
         if (e == 6) chk("d2_e6_ready", 16'(READY2), 16'h1);
         if (e == 6) chk("d2_e6_rn", 16'(RN_OUT2), 16'h1);
         if (e == 10) chk("e10_rn", 16'(RN_OUT), 16'h0);
         if (e == 11) chk("e11_rn", 16'(RN_OUT), 16'h1);
         if (e == 11) chk("e11_ready", 16'(READY), 16'h0);
         if (e == 12) chk("e12_rn", 16'(RN_OUT), 16'h3);
         if (e == 13) chk("e13_rn", 16'(RN_OUT), 16'h7);
         if (e == 13) chk("e13_ready", 16'(READY), 16'h0);
         if (e == 14) chk("e14_rn", 16'(RN_OUT), 16'hF);
         if (e == 14) chk("e14_ready", 16'(READY), 16'h1);
      end

      // Preset handshake: request sampled at edge 15.
      PRE_REQ = 1'b1;
      step(); // 15
      chk("p15_setn", 16'(SETN_OUT), 16'h1);
      chk("p15_ready", 16'(READY), 16'h1);
      step(); // 16
      chk("p16_setn", 16'(SETN_OUT), 16'h0);
      chk("p16_ready", 16'(READY), 16'h0);
      step(); // 17
      chk("p17_setn", 16'(SETN_OUT), 16'h0);
      chk("p17_ack", 16'(PRE_ACK), 16'h0);
      step(); // 18
      chk("p18_setn", 16'(SETN_OUT), 16'h1);
      chk("p18_ack", 16'(PRE_ACK), 16'h1);
      chk("p18_ready", 16'(READY), 16'h0);
      step(); // 19, still high: PACK holds
      chk("p19_ack_hold", 16'(PRE_ACK), 16'h1);
      PRE_REQ = 1'b0;
      step(); // 20
      chk("p20_ack", 16'(PRE_ACK), 16'h0);
      chk("p20_ready", 16'(READY), 16'h1);

      // Request dropped mid-pulse: full pulse width, immediate PACK exit.
      PRE_REQ = 1'b1;
      step(); // 21
      chk("q21_setn", 16'(SETN_OUT), 16'h1);
      step(); // 22
      chk("q22_setn", 16'(SETN_OUT), 16'h0);
      PRE_REQ = 1'b0;
      step(); // 23
      chk("q23_setn", 16'(SETN_OUT), 16'h0);
      step(); // 24
      chk("q24_setn", 16'(SETN_OUT), 16'h1);
      chk("q24_ack", 16'(PRE_ACK), 16'h1);
      step(); // 25
      chk("q25_ack", 16'(PRE_ACK), 16'h0);
      chk("q25_ready", 16'(READY), 16'h1);
      step(); // 26
      chk("q26_no_retrig", 16'(SETN_OUT), 16'h1);

      // Sub-cycle reset pulse from RUN, then reset again at HOLD count 3.
      RN = 1'b0;
      #1 chk_rst("rst_run");
      #1 RN = 1'b1;
      repeat (8) step();
      chk("hold_rn", 16'(RN_OUT), 16'h0);
      RN = 1'b0;
      #1 chk_rst("rst_hold");
      #1 RN = 1'b1;
      PRE_REQ = 1'b1;

      // Full restart with PRE_REQ held high from release.
      for (int e = 1; e <= 15; e++) begin
         step();
         if (e < 15) chk("r_setn_hi", 16'(SETN_OUT), 16'h1);
         if (e == 10) chk("r10_rn", 16'(RN_OUT), 16'h0);
         if (e == 11) chk("r11_rn", 16'(RN_OUT), 16'h1);
         if (e == 14) chk("r14_rn", 16'(RN_OUT), 16'hF);
         if (e == 14) chk("r14_ready", 16'(READY), 16'h1);
         if (e == 15) chk("r15_setn", 16'(SETN_OUT), 16'h0);
         if (e == 15) chk("r15_rn", 16'(RN_OUT), 16'hF);
      end

      // Reset during the preset pulse.
      RN = 1'b0;
      #1 chk_rst("rst_pset");
      step();
      chk_rst("rst_pset_held");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
